instr_exec_sequencer: RTL

- Sequencer that walks a programmable address range of the instruction register and executes each stored instruction_t on a shared ALU with opcode-dependent multi-cycle latency.
- Results go to a writeback port using a valid/ready handshake.
- Sits between the instruction register's read port and the result store or scoreboard.
- Processes one instruction at a time, in address order.

---
 rtl/instr_exec_sequencer_pkg.sv | 52 +++++
 rtl/instr_exec_sequencer_alu.sv | 46 ++++
 rtl/instr_exec_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/instr_exec_sequencer_pkg.sv
// Shared types for the instruction register and the execution sequencer.
// Holds the opcode encoding, instruction layout, sequencer states and latency lookup.
package instr_exec_sequencer_pkg;

    localparam int unsigned ADDR_DEPTH = 32;
    localparam int unsigned ADDR_W     = $clog2(ADDR_DEPTH);
    localparam int unsigned OPND_W     = 32;
    localparam int unsigned RES_W      = 64;

    typedef logic [ADDR_W-1:0] address_t;
    typedef logic [OPND_W-1:0] operand_t;
    typedef logic [RES_W-1:0]  result_t;

    // Encodings 8..15 are reserved and decode as illegal.
    typedef enum logic [3:0] {
        ZERO  = 4'h0,
        PASSA = 4'h1,
        PASSB = 4'h2,
        ADD   = 4'h3,
        SUB   = 4'h4,
        MULT  = 4'h5,
        DIV   = 4'h6,
        MOD   = 4'h7
    } opcode_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        WB,
        DONE
    } exec_state_t;

    function automatic int unsigned op_latency(input opcode_t     opc,
                                               input int unsigned mult_lat,
                                               input int unsigned div_lat);
        int unsigned lat;
        case (opc)
            MULT:     lat = mult_lat;
            DIV, MOD: lat = div_lat;
            default:  lat = 1;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/instr_exec_sequencer_alu.sv
// Combinational 64-bit signed ALU for one instruction_t.
// Operands are sign-extended from 32 bits; divide-by-zero and reserved opcodes yield 0.
module instr_exec_alu
    import instr_exec_sequencer_pkg::*;
(
    input  instruction_t instr,
    output result_t      result,
    output logic         div_zero,
    output logic         illegal
);

    logic signed [RES_W-1:0] a;
    logic signed [RES_W-1:0] b;
    logic signed [RES_W-1:0] b_safe;
    logic                    b_is_zero;

    assign a         = {{(RES_W-OPND_W){instr.op_a[OPND_W-1]}}, instr.op_a};
    assign b         = {{(RES_W-OPND_W){instr.op_b[OPND_W-1]}}, instr.op_b};
    assign b_is_zero = (instr.op_b == '0);
    // Keeps the divider input defined when the zero-divisor path is taken.
    assign b_safe    = b_is_zero ? 64'sd1 : b;

    always_comb begin
        result   = '0;
        div_zero = 1'b0;
        illegal  = 1'b0;
        case (instr.opc)
            ZERO:  result = '0;
            PASSA: result = a;
            PASSB: result = b;
            ADD:   result = a + b;
            SUB:   result = a - b;
            MULT:  result = a * b;
            DIV: begin
                if (b_is_zero) div_zero = 1'b1;
                else           result   = a / b_safe;
            end
            MOD: begin
                if (b_is_zero) div_zero = 1'b1;
                else           result   = a % b_safe;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_exec_sequencer.sv
// Walks an address range of the instruction register, executes each instruction on the ALU
// with opcode-dependent latency and hands results out over a valid/ready writeback port.
module instr_exec_sequencer
    import instr_exec_sequencer_pkg::*;
#(
    parameter int unsigned MULT_LAT = 3,
    parameter int unsigned DIV_LAT  = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  address_t     first_addr,
    input  address_t     last_addr,
    output address_t     read_pointer,
    input  instruction_t instruction_word,
    output logic         wb_valid,
    input  logic         wb_ready,
    output address_t     wb_addr,
    output result_t      wb_result,
    output logic         busy,
    output logic         done,
    output logic         div_zero_err,
    output logic         illegal_op_err
);

    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    exec_state_t  state_q;
    address_t     rp_q;
    address_t     last_q;
    instruction_t iw_q;
    cnt_t         cnt_q;
    logic         wb_valid_q;
    address_t     wb_addr_q;
    result_t      wb_result_q;
    logic         done_q;
    logic         div_zero_q;
    logic         illegal_q;

    result_t      alu_result;
    logic         alu_div_zero;
    logic         alu_illegal;
    cnt_t         fetch_cnt;

    instr_exec_alu u_alu (
        .instr    (iw_q),
        .result   (alu_result),
        .div_zero (alu_div_zero),
        .illegal  (alu_illegal)
    );

    assign fetch_cnt = cnt_t'(op_latency(instruction_word.opc, MULT_LAT, DIV_LAT) - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rp_q        <= '0;
            last_q      <= '0;
            iw_q        <= '0;
            cnt_q       <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_result_q <= '0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rp_q       <= first_addr;
                        last_q     <= last_addr;
                        div_zero_q <= 1'b0;
                        illegal_q  <= 1'b0;
                        state_q    <= FETCH;
                    end
                end
                FETCH: begin
                    iw_q    <= instruction_word;
                    cnt_q   <= fetch_cnt;
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        wb_result_q <= alu_result;
                        wb_addr_q   <= rp_q;
                        wb_valid_q  <= 1'b1;
                        if (alu_div_zero) div_zero_q <= 1'b1;
                        if (alu_illegal)  illegal_q  <= 1'b1;
                        state_q     <= WB;
                    end else begin
                        cnt_q <= cnt_q - cnt_t'(1);
                    end
                end
                WB: begin
                    if (wb_ready) begin
                        wb_valid_q <= 1'b0;
                        if (rp_q == last_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            // Address arithmetic is modulo the register depth.
                            rp_q    <= rp_q + address_t'(1);
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_pointer   = rp_q;
    assign wb_valid       = wb_valid_q;
    assign wb_addr        = wb_addr_q;
    assign wb_result      = wb_result_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign div_zero_err   = div_zero_q;
    assign illegal_op_err = illegal_q;

endmodule
